// File: rtl/link_pkg.sv
// Shared definitions for the game link: frame geometry, FSM state encoding
// and the parity rule used by both the transmitter and the receiver.
package link_pkg;

  localparam int FRAME_BITS = 35;
  localparam int DATA_BITS  = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } link_state_t;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/game_link_if.sv
// Processor-side bus of the game link: send strobe and word, transmit status,
// and receive notification with the last good word.
interface game_link_if;
  import link_pkg::*;

  logic                 snd;
  logic [DATA_BITS-1:0] interface_data;
  logic                 tx_busy;
  logic                 tx_drop;
  logic                 interrupt_eth;
  logic [DATA_BITS-1:0] interrupt_source_data;
  logic                 rx_err;

  modport master (
    output snd, interface_data,
    input  tx_busy, tx_drop, interrupt_eth, interrupt_source_data, rx_err
  );

  modport slave (
    input  snd, interface_data,
    output tx_busy, tx_drop, interrupt_eth, interrupt_source_data, rx_err
  );

endinterface

// File: rtl/game_link_rx.sv
// Game link receiver: 2-flop synchronizer, start-bit glitch filter, mid-bit
// sampling of a 35-bit frame, parity/stop check and word delivery.
module game_link_rx
  import link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] word,
  output logic                 valid,
  output logic                 err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

  logic                 rx_p0, rx_p1, rx_prev;
  link_state_t          state;
  logic [CNT_W-1:0]     cyc;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 sample;

  // Synchronizer stage p0 -> p1; rx_prev holds the previous synchronized level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0   <= 1'b1;
      rx_p1   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_p0   <= rx;
      rx_p1   <= rx_p0;
      rx_prev <= rx_p1;
    end
  end

  // The start bit is checked at its midpoint; every later bit one period on.
  assign sample = (state == START) ? (cyc == HALF_LAST) : (cyc == CNT_LAST);

  always_ff @(posedge clk) begin
    if (sample && state == DATA)   shift   <= {rx_p1, shift[DATA_BITS-1:1]};
    if (sample && state == PARITY) par_bit <= rx_p1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cyc     <= '0;
      bit_idx <= '0;
      word    <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          // A falling edge needs a prior high, so a line stuck low never re-arms.
          if (rx_prev && !rx_p1) begin
            state <= START;
            cyc   <= '0;
          end
        end
        START: begin
          if (sample) begin
            cyc     <= '0;
            bit_idx <= '0;
            state   <= rx_p1 ? IDLE : DATA;
          end else begin
            cyc <= cyc + CNT_W'(1);
          end
        end
        DATA: begin
          if (sample) begin
            cyc <= '0;
            if (bit_idx == DATA_LAST) state <= PARITY;
            else                      bit_idx <= bit_idx + BIT_W'(1);
          end else begin
            cyc <= cyc + CNT_W'(1);
          end
        end
        PARITY: begin
          if (sample) begin
            cyc   <= '0;
            state <= STOP;
          end else begin
            cyc <= cyc + CNT_W'(1);
          end
        end
        STOP: begin
          if (sample) begin
            cyc   <= '0;
            state <= IDLE;
            if (rx_p1 && (par_bit == even_parity(shift))) begin
              word  <= shift;
              valid <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end else begin
            cyc <= cyc + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/game_link.sv
// Game link top: one-word transmit holding register feeding a 35-bit serializer,
// plus the independent receiver in game_link_rx.
module game_link
  import link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  game_link_if.slave bus,
  output logic       tx,
  input  logic       rx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

  link_state_t          state;
  logic                 hold_full, drop, tx_q, par;
  logic [DATA_BITS-1:0] hold_data, shift;
  logic [CNT_W-1:0]     cyc;
  logic [BIT_W-1:0]     bit_idx;
  logic                 bit_end, accept, load_shift, shift_now;
  logic [DATA_BITS-1:0] rx_word;
  logic                 rx_valid, rx_bad;

  assign bit_end    = (cyc == CNT_LAST);
  assign accept     = bus.snd && !hold_full;
  assign load_shift = hold_full && ((state == IDLE) || (state == STOP && bit_end));
  assign shift_now  = (state == DATA) && bit_end;

  always_ff @(posedge clk) begin
    if (accept) hold_data <= bus.interface_data;
  end

  // Shifter stage: parity is fixed when the word leaves the holding register.
  always_ff @(posedge clk) begin
    if (load_shift) begin
      shift <= hold_data;
      par   <= even_parity(hold_data);
    end else if (shift_now) begin
      shift <= shift >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      drop      <= 1'b0;
      tx_q      <= 1'b1;
      cyc       <= '0;
      bit_idx   <= '0;
    end else begin
      drop <= bus.snd && hold_full;
      if (accept)     hold_full <= 1'b1;
      if (load_shift) hold_full <= 1'b0;
      case (state)
        IDLE: begin
          if (hold_full) begin
            state <= START;
            tx_q  <= 1'b0;
            cyc   <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx_q    <= shift[0];
            cyc     <= '0;
            bit_idx <= '0;
          end else begin
            cyc <= cyc + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cyc <= '0;
            if (bit_idx == DATA_LAST) begin
              state <= PARITY;
              tx_q  <= par;
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
              tx_q    <= shift[1];
            end
          end else begin
            cyc <= cyc + CNT_W'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx_q  <= 1'b1;
            cyc   <= '0;
          end else begin
            cyc <= cyc + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cyc <= '0;
            // A waiting word starts immediately: no idle bit between frames.
            if (hold_full) begin
              state <= START;
              tx_q  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cyc <= cyc + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx          = tx_q;
  assign bus.tx_busy = hold_full || (state != IDLE);
  assign bus.tx_drop = drop;

  game_link_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .word (rx_word),
    .valid(rx_valid),
    .err  (rx_bad)
  );

  assign bus.interrupt_source_data = rx_word;
  assign bus.interrupt_eth         = rx_valid;
  assign bus.rx_err                = rx_bad;

endmodule

// File: doc/game_link.md
GAME_LINK -- requirements
Module: game_link

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port snd  input  1  processor send strobe, one cycle, qualifies interface_data.
REQ-006 SHALL have port interface_data  input  32  word to transmit.
REQ-007 SHALL have port tx_busy  output  1  high while the holding register or the shifter is occupied.
REQ-008 SHALL have port tx_drop  output  1  one-cycle pulse when snd is refused.
REQ-009 SHALL have port tx  output  1  serial line to the opponent board; idle high.
REQ-010 SHALL have port rx  input  1  serial line from the opponent board; asynchronous to clk.
REQ-011 SHALL have port interrupt_eth  output  1  one-cycle pulse when a valid word is received.
REQ-012 SHALL have port interrupt_source_data  output  32  last valid received word.
REQ-013 SHALL have port rx_err  output  1  one-cycle pulse on a parity or framing error.

Function
REQ-014 Frame SHALL be 35 bits: start (0), data[0]..data[31] LSB first, even parity over the 32 data bits, stop (1); each bit lasts exactly CLKS_PER_BIT cycles.
REQ-015 TX SHALL have a one-word holding register; snd with the holding register empty latches interface_data the same edge.
REQ-016 snd with the holding register full SHALL be ignored, with tx_drop pulsed on the next cycle; held data SHALL be unchanged.
REQ-017 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; IDLE->START occurs on the edge after the holding register is loaded; the holding register is freed the same edge.
REQ-018 tx SHALL be registered; tx falls one cycle after snd when TX is idle.
REQ-019 STOP->START SHALL follow directly, with no idle bit, when the holding register is full at the end of the stop bit; otherwise STOP->IDLE.
REQ-020 tx_busy SHALL be high from the cycle after an accepted snd until the end of the last stop bit with the holding register empty.
REQ-021 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-022 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-023 IDLE->START SHALL occur on a synchronized high-to-low transition.
REQ-024 In START, the line SHALL be resampled after CLKS_PER_BIT/2 cycles (integer divide); if high, the FSM returns to IDLE with no error (glitch).
REQ-025 Subsequent bits SHALL be sampled every CLKS_PER_BIT cycles from the start-bit midpoint.
REQ-026 At the stop-bit sample, if parity matches and stop=1, interrupt_source_data SHALL update and interrupt_eth SHALL pulse on the following cycle.
REQ-027 At the stop-bit sample, if parity mismatches or stop=0, rx_err SHALL pulse on the following cycle and interrupt_source_data SHALL keep its previous value.
REQ-028 After the stop-bit sample, RX SHALL return to IDLE; on a framing error it waits for rx high before re-arming.
REQ-029 TX and RX SHALL be fully independent; simultaneous snd and reception SHALL not interact.
REQ-030 Bit counters SHALL be sized for 35 bits and the cycle counter for CLKS_PER_BIT-1 without overflow or wrap.

Reset
REQ-031 rst SHALL force, immediately: tx=1, tx_busy=0, tx_drop=0, interrupt_eth=0, rx_err=0, interrupt_source_data=0, both FSMs IDLE, holding register empty, synchronizer flops=1.
REQ-032 rst mid-frame SHALL abort the frame with no pulse emitted.
REQ-033 A partial received frame SHALL be discarded on rst.
REQ-034 The first post-reset snd SHALL behave as REQ-018.

Structure
REQ-035 Package link_pkg SHALL hold the shared FSM state enum, FRAME_BITS=35, DATA_BITS=32, and the even-parity function.
REQ-036 The receiver (synchronizer, RX FSM, shifter) SHALL be sub-module game_link_rx; TX SHALL remain in game_link.

Verification (CLKS_PER_BIT=4)
REQ-037 snd with 0xDEADBEEF and tx looped to rx -> tx low at cycle 1, frame of 140 cycles, interrupt_eth one pulse, interrupt_source_data=0xDEADBEEF, rx_err=0.
REQ-038 snd 0x00000001 then snd 0x12345678 two cycles later, then a third snd while busy -> two back-to-back frames with no idle gap, tx_drop one pulse, both words received in order.
REQ-039 Driven rx frame with flipped parity bit, data 0xA5A5A5A5 -> rx_err one pulse, no interrupt_eth, interrupt_source_data unchanged.
REQ-040 rx low for 1 cycle only -> no interrupt_eth, no rx_err; a following valid frame 0x0000FFFF is received correctly.
REQ-041 Driven frame with stop=0 -> rx_err pulse; rx held low then released high -> next valid frame 0xCAFEF00D received.
REQ-042 rst asserted at bit 10 of a transmit -> tx=1 and tx_busy=0 immediately, no interrupt_eth; next snd 0x00000055 frames correctly.
